msx_bus_initiator: RTL and testbench

Host-side MSX slot bus initiator: turns single-beat read/write requests from an internal core into Z80-timed memory or I/O cycles on a cartridge-facing bus. It drives the slot-select, strobe and address signals, honours WAIT_n, and returns read data. It optionally runs DRAM refresh cycles. It is the initiator counterpart of the cartridge-side mapper and RAM controllers, and is used to drive cartridge-side logic in simulation and in host builds.

---
 rtl/msx_bus_initiator.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_msx_bus_initiator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/msx_bus_initiator.sv
// MSX slot bus initiator: single-beat core requests become Z80-timed memory/I/O cycles.
// Define MSX_BUS_INITIATOR_RFSH_EN to build the R1/R2 DRAM refresh cycles after M1 fetches.
module msx_bus_initiator #(
    parameter int DIV      = 4,
    parameter int MAX_WAIT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_VALID,
    output logic        REQ_READY,
    input  logic        REQ_WRITE,
    input  logic        REQ_IO,
    input  logic        REQ_M1,
    input  logic        REQ_SLOT,
    input  logic [15:0] REQ_ADDR,
    input  logic [7:0]  REQ_DATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        RSP_TIMEOUT,
    output logic [15:0] ADDR,
    output logic [7:0]  DIN,
    output logic        RD_n,
    output logic        WR_n,
    output logic        MERQ_n,
    output logic        IORQ_n,
    output logic        SLTSL_n,
    output logic        CS1_n,
    output logic        CS2_n,
    output logic        CS12_n,
    output logic        M1_n,
    output logic        RFSH_n,
    output logic        CLK_EN,
    input  logic [7:0]  DOUT,
    input  logic        BUSDIR_n,
    input  logic        WAIT_n,
    input  logic        INT_n,
    output logic        INT_PENDING
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_R1, S_R2} state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        ready_q, ready_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  din_q, din_d;
    logic        rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic        merq_n_q, merq_n_d, iorq_n_q, iorq_n_d;
    logic        sltsl_n_q, sltsl_n_d, m1_n_q, m1_n_d;
    logic        cs1_n_q, cs1_n_d, cs2_n_q, cs2_n_d;
    logic        rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  rsp_data_q, rsp_data_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        abort_q, abort_d;
    logic        lat_write_q, lat_write_d, lat_io_q, lat_io_d;
    logic [7:0]  lat_data_q, lat_data_d;
    logic        int_s1_q, int_s1_d, int_s2_q, int_s2_d;
    logic        clk_en;
    logic [7:0]  sample_val;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
    logic        rfsh_n_q, rfsh_n_d, lat_m1_q, lat_m1_d;
    logic [6:0]  rcnt_q, rcnt_d;
`endif

    assign clk_en     = (div_q == DIV_LAST);
    assign sample_val = lat_write_q ? rsp_data_q : (BUSDIR_n ? 8'hFF : DOUT);

    always_comb begin
        state_d       = state_q;
        div_d         = clk_en ? 8'd0 : div_q + 8'd1;
        addr_d        = addr_q;
        din_d         = din_q;
        rd_n_d        = rd_n_q;
        wr_n_d        = wr_n_q;
        merq_n_d      = merq_n_q;
        iorq_n_d      = iorq_n_q;
        sltsl_n_d     = sltsl_n_q;
        m1_n_d        = m1_n_q;
        cs1_n_d       = cs1_n_q;
        cs2_n_d       = cs2_n_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_data_d    = rsp_data_q;
        wcnt_d        = wcnt_q;
        abort_d       = abort_q;
        lat_write_d   = lat_write_q;
        lat_io_d      = lat_io_q;
        lat_data_d    = lat_data_q;
        int_s1_d      = ~INT_n;
        int_s2_d      = int_s1_q;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
        rfsh_n_d      = rfsh_n_q;
        lat_m1_d      = lat_m1_q;
        rcnt_d        = rcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ_VALID && ready_q) begin
                    state_d     = S_T1;
                    div_d       = 8'd0;
                    wcnt_d      = 8'd0;
                    abort_d     = 1'b0;
                    lat_write_d = REQ_WRITE;
                    lat_io_d    = REQ_IO;
                    lat_data_d  = REQ_DATA;
                    addr_d      = REQ_ADDR;
                    iorq_n_d    = ~REQ_IO;
                    merq_n_d    = REQ_IO;
                    rd_n_d      = REQ_WRITE;
                    m1_n_d      = ~(REQ_M1 & ~REQ_IO & ~REQ_WRITE);
                    sltsl_n_d   = ~(REQ_SLOT & ~REQ_IO);
                    cs1_n_d     = ~(~REQ_IO && REQ_ADDR[15:14] == 2'b01);
                    cs2_n_d     = ~(~REQ_IO && REQ_ADDR[15:14] == 2'b10);
`ifdef MSX_BUS_INITIATOR_RFSH_EN
                    lat_m1_d    = REQ_M1 & ~REQ_IO & ~REQ_WRITE;
`endif
                end
            end
            S_T1: begin
                if (clk_en) begin
                    state_d = S_T2;
                    if (lat_write_q) begin
                        din_d  = lat_data_q;
                        wr_n_d = 1'b0;
                    end
                end
            end
            S_T2: begin
                if (clk_en) begin
                    if (!WAIT_n || lat_io_q) begin
                        state_d = S_TW;
                    end else begin
                        state_d    = S_T3;
                        rsp_data_d = sample_val;
                    end
                end
            end
            S_TW: begin
                // I/O's mandatory TW is covered by the T2 exit; here only WAIT_n holds us
                if (clk_en) begin
                    wcnt_d = wcnt_q + 8'd1;
                    if (WAIT_n || (wcnt_q + 8'd1 == WAIT_LIM)) begin
                        state_d    = S_T3;
                        abort_d    = ~WAIT_n;
                        rsp_data_d = sample_val;
                    end
                end
            end
            S_T3: begin
                if (clk_en) begin
                    rd_n_d        = 1'b1;
                    wr_n_d        = 1'b1;
                    merq_n_d      = 1'b1;
                    iorq_n_d      = 1'b1;
                    sltsl_n_d     = 1'b1;
                    m1_n_d        = 1'b1;
                    cs1_n_d       = 1'b1;
                    cs2_n_d       = 1'b1;
                    din_d         = 8'h00;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = abort_q;
                    state_d       = S_IDLE;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
                    if (lat_m1_q) begin
                        state_d  = S_R1;
                        rfsh_n_d = 1'b0;
                        merq_n_d = 1'b0;
                        addr_d   = {9'h000, rcnt_q};
                    end
`endif
                end
            end
`ifdef MSX_BUS_INITIATOR_RFSH_EN
            S_R1: begin
                if (clk_en) state_d = S_R2;
            end
            S_R2: begin
                if (clk_en) begin
                    state_d  = S_IDLE;
                    rfsh_n_d = 1'b1;
                    merq_n_d = 1'b1;
                    rcnt_d   = rcnt_q + 7'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= S_IDLE;
            div_q         <= 8'd0;
            ready_q       <= 1'b0;
            addr_q        <= 16'h0000;
            din_q         <= 8'h00;
            rd_n_q        <= 1'b1;
            wr_n_q        <= 1'b1;
            merq_n_q      <= 1'b1;
            iorq_n_q      <= 1'b1;
            sltsl_n_q     <= 1'b1;
            m1_n_q        <= 1'b1;
            cs1_n_q       <= 1'b1;
            cs2_n_q       <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 8'hFF;
            wcnt_q        <= 8'd0;
            abort_q       <= 1'b0;
            lat_write_q   <= 1'b0;
            lat_io_q      <= 1'b0;
            lat_data_q    <= 8'h00;
            int_s1_q      <= 1'b0;
            int_s2_q      <= 1'b0;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
            rfsh_n_q      <= 1'b1;
            lat_m1_q      <= 1'b0;
            rcnt_q        <= 7'd0;
`endif
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            ready_q       <= ready_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            merq_n_q      <= merq_n_d;
            iorq_n_q      <= iorq_n_d;
            sltsl_n_q     <= sltsl_n_d;
            m1_n_q        <= m1_n_d;
            cs1_n_q       <= cs1_n_d;
            cs2_n_q       <= cs2_n_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
            wcnt_q        <= wcnt_d;
            abort_q       <= abort_d;
            lat_write_q   <= lat_write_d;
            lat_io_q      <= lat_io_d;
            lat_data_q    <= lat_data_d;
            int_s1_q      <= int_s1_d;
            int_s2_q      <= int_s2_d;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
            rfsh_n_q      <= rfsh_n_d;
            lat_m1_q      <= lat_m1_d;
            rcnt_q        <= rcnt_d;
`endif
        end
    end

    assign REQ_READY   = ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_DATA    = rsp_data_q;
    assign RSP_TIMEOUT = rsp_timeout_q;
    assign ADDR        = addr_q;
    assign DIN         = din_q;
    assign RD_n        = rd_n_q;
    assign WR_n        = wr_n_q;
    assign MERQ_n      = merq_n_q;
    assign IORQ_n      = iorq_n_q;
    assign SLTSL_n     = sltsl_n_q;
    assign M1_n        = m1_n_q;
    assign CS1_n       = cs1_n_q;
    assign CS2_n       = cs2_n_q;
    assign CS12_n      = cs1_n_q & cs2_n_q;
    assign CLK_EN      = clk_en;
    // High means an interrupt is being requested (INT_n low, synchronised)
    assign INT_PENDING = int_s2_q;
`ifdef MSX_BUS_INITIATOR_RFSH_EN
    assign RFSH_n      = rfsh_n_q;
`else
    assign RFSH_n      = 1'b1;
`endif

endmodule

// File: tb/tb_msx_bus_initiator.sv
// Scoreboard bench for msx_bus_initiator (DIV=4, MAX_WAIT=5); adapts to MSX_BUS_INITIATOR_RFSH_EN.
module tb_msx_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ_VALID = 1'b0, REQ_WRITE = 1'b0, REQ_IO = 1'b0, REQ_M1 = 1'b0, REQ_SLOT = 1'b0;
    logic [15:0] REQ_ADDR = 16'h0;
    logic [7:0]  REQ_DATA = 8'h0, DOUT = 8'h0;
    logic        BUSDIR_n = 1'b1, WAIT_n = 1'b1, INT_n = 1'b1;
    logic        REQ_READY, RSP_VALID, RSP_TIMEOUT, CLK_EN, INT_PENDING;
    logic [7:0]  RSP_DATA, DIN;
    logic [15:0] ADDR;
    logic        RD_n, WR_n, MERQ_n, IORQ_n, SLTSL_n, CS1_n, CS2_n, CS12_n, M1_n, RFSH_n;

    msx_bus_initiator #(.DIV(4), .MAX_WAIT(5)) dut (
        .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_WRITE(REQ_WRITE), .REQ_IO(REQ_IO), .REQ_M1(REQ_M1), .REQ_SLOT(REQ_SLOT),
        .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
        .RSP_TIMEOUT(RSP_TIMEOUT), .ADDR(ADDR), .DIN(DIN), .RD_n(RD_n), .WR_n(WR_n),
        .MERQ_n(MERQ_n), .IORQ_n(IORQ_n), .SLTSL_n(SLTSL_n), .CS1_n(CS1_n), .CS2_n(CS2_n),
        .CS12_n(CS12_n), .M1_n(M1_n), .RFSH_n(RFSH_n), .CLK_EN(CLK_EN), .DOUT(DOUT),
        .BUSDIR_n(BUSDIR_n), .WAIT_n(WAIT_n), .INT_n(INT_n), .INT_PENDING(INT_PENDING)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       chk_data;
        logic       timeout;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   hs = 0;
    int   kk = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [9:0] strobes();
        return {RD_n, WR_n, MERQ_n, IORQ_n, SLTSL_n, CS1_n, CS2_n, CS12_n, M1_n, RFSH_n};
    endfunction

    // Monitor: every response pulse is matched against the oldest expectation
    always @(negedge CLK) begin
        if (!RESET && RSP_VALID) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_latency", 32'(cyc), 32'(e.cyc));
                check("rsp_timeout", {31'd0, RSP_TIMEOUT}, {31'd0, e.timeout});
                if (e.chk_data) check("rsp_data", {24'd0, RSP_DATA}, {24'd0, e.data});
            end
        end
    end

    task automatic at_k(input int k);
        while (kk < k) begin
            @(negedge CLK);
            kk++;
        end
    endtask

    // Handshake on the next ready edge; returns at the negedge after it (k = 0)
    task automatic issue(input logic wr, input logic io, input logic m1, input logic slot,
                         input logic [15:0] a, input logic [7:0] d, input bit push,
                         input logic [7:0] ed, input logic echk, input logic eto, input int lat);
        int n;
        n = 0;
        while (!REQ_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) check("ready_timeout", 32'd0, 32'd1);
        REQ_WRITE = wr; REQ_IO = io; REQ_M1 = m1; REQ_SLOT = slot;
        REQ_ADDR = a; REQ_DATA = d; REQ_VALID = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        REQ_VALID = 1'b0;
        hs = cyc;
        kk = 0;
        if (push) sb.push_back('{data: ed, chk_data: echk, timeout: eto, cyc: hs + lat});
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge CLK);
        check("rst_ready", {31'd0, REQ_READY}, 32'd0);
        check("rst_strobes", {22'd0, strobes()}, 32'h3FF);
        check("rst_addr_din", {8'd0, ADDR, DIN}, 32'h0);
        check("rst_rsp", {22'd0, RSP_VALID, RSP_TIMEOUT, RSP_DATA}, 32'h0FF);
        check("rst_clken_int", {30'd0, CLK_EN, INT_PENDING}, 32'd0);
        RESET = 1'b0;
        #1 check("ready_before_clk", {31'd0, REQ_READY}, 32'd0);
        @(negedge CLK);
        check("ready_after_clk", {31'd0, REQ_READY}, 32'd1);

        // Memory read, slot 1 page: 3 T-states
        BUSDIR_n = 1'b0; DOUT = 8'hA5;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 12);
        at_k(2);
        check("mrd_strobes", {22'd0, strobes()}, 32'b0101001011);
        check("mrd_addr", {16'd0, ADDR}, 32'h4000);
        check("mrd_ready", {31'd0, REQ_READY}, 32'd0);
        drain();
        check("mrd_release", {22'd0, strobes()}, 32'h3FF);

        // Memory write: WR_n low exactly in T2 and T3
        BUSDIR_n = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 16'h6000, 8'h03, 1'b1, 8'h00, 1'b0, 1'b0, 12);
        at_k(2);
        check("mwr_cs", {29'd0, CS1_n, CS2_n, CS12_n}, 32'b010);
        for (int k = 1; k <= 12; k++) begin
            at_k(k);
            check("mwr_wr_n", {31'd0, WR_n}, {31'd0, !(k >= 4 && k <= 11)});
            check("mwr_din", {24'd0, DIN}, (k >= 4 && k <= 11) ? 32'h03 : 32'h00);
        end
        drain();

        // I/O read, no cartridge drive: 4 T-states, 8'hFF
        DOUT = 8'h77;
        issue(1'b0, 1'b1, 1'b0, 1'b1, 16'h0098, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 16);
        at_k(2);
        check("iord_strobes", {22'd0, strobes()}, 32'b0110111111);
        drain();

        // WAIT_n held low: aborts after 5 TW states; a mid-cycle request is ignored
        WAIT_n = 1'b0; BUSDIR_n = 1'b0; DOUT = 8'h5A;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h8000, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1, 32);
        at_k(15);
        REQ_VALID = 1'b1;
        at_k(16);
        REQ_VALID = 1'b0;
        check("tmo_busy_ready", {31'd0, REQ_READY}, 32'd0);
        drain();
        check("tmo_release", {22'd0, strobes()}, 32'h3FF);
        WAIT_n = 1'b1;
        repeat (20) @(negedge CLK);

        // WAIT_n low for 2 T-states, with a glitch between CLK_EN pulses
        WAIT_n = 1'b0; DOUT = 8'h3C;
        issue(1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b0, 20);
        at_k(9);  WAIT_n = 1'b1;
        at_k(11); WAIT_n = 1'b0;
        at_k(13); WAIT_n = 1'b1;
        drain();

        // Three M1 fetches; refresh follows each in the refresh build
        for (int i = 0; i < 3; i++) begin
            DOUT = 8'h10 + 8'(i);
            issue(1'b0, 1'b0, 1'b1, 1'b0, 16'(i * 16), 8'h00, 1'b1, 8'h10 + 8'(i), 1'b1, 1'b0, 12);
            at_k(2);
            check("m1_strobes", {22'd0, strobes()}, 32'b0101111101);
`ifdef MSX_BUS_INITIATOR_RFSH_EN
            at_k(14);
            check("rfsh_strobes", {22'd0, strobes()}, 32'b1101111110);
            check("rfsh_addr", {16'd0, ADDR}, 32'(i));
            at_k(18);
            check("rfsh_ready_lo", {31'd0, REQ_READY}, 32'd0);
            at_k(21);
            check("rfsh_ready_hi", {31'd0, REQ_READY}, 32'd1);
            check("rfsh_release", {22'd0, strobes()}, 32'h3FF);
`else
            at_k(13);
            check("m1_ready", {31'd0, REQ_READY}, 32'd1);
            check("m1_rfsh_n", {31'd0, RFSH_n}, 32'd1);
`endif
            drain();
        end

        // RESET during TW: strobes high at once and no response
        WAIT_n = 1'b0;
        issue(1'b0, 1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 0);
        at_k(10);
        check("tw_strobes", {22'd0, strobes()}, 32'b0101001011);
        RESET = 1'b1;
        #1;
        check("midrst_strobes", {22'd0, strobes()}, 32'h3FF);
        check("midrst_out", {13'd0, REQ_READY, RSP_VALID, CLK_EN, DIN, RSP_DATA}, 32'h000FF);
        WAIT_n = 1'b1;
        at_k(11);
        RESET = 1'b0;
        at_k(12);
        check("midrst_ready", {31'd0, REQ_READY}, 32'd1);
        repeat (30) @(negedge CLK);

        // INT_n synchroniser: two CLKs of latency
        INT_n = 1'b0;
        @(negedge CLK);
        check("int_1clk", {31'd0, INT_PENDING}, 32'd0);
        @(negedge CLK);
        check("int_2clk", {31'd0, INT_PENDING}, 32'd1);
        INT_n = 1'b1;

        repeat (4) @(negedge CLK);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
